// File: rtl/operand_pkg.sv
// Shared definitions for the operand register file slice.
//   DW        - data width, matches the ALU operand width
//   NREG      - number of architectural registers (power of two)
//   RSEL_W    - register index width
//   reg_sel_t - register index type used on every select port
package operand_pkg;
   localparam int unsigned DW     = 16;
   localparam int unsigned NREG   = 8;
   localparam int unsigned RSEL_W = 3;

   typedef logic [RSEL_W-1:0] reg_sel_t;
endpackage

// File: rtl/operand_scoreboard.sv
// Write-back scoreboard: one pending bit per register, set/clear priority,
// sticky WAW / unexpected write-back error flag, and combinational stall.
// Optional feature macro: OPERAND_REGFILE_BYPASS_EN (a same-cycle write to a
// source register suppresses that source's stall).
// Ports:
//   clk, rst_n        - clock, asynchronous active-low reset
//   rd1_en/rd1_sel    - port-1 live read and its index
//   rd2_en/rd2_sel    - port-2 live read and its index
//   wr_en/wr_sel      - write-back strobe and index
//   iss_en/iss_sel    - issuing instruction destination
//   stall             - a live source is pending
//   pend              - pending bit per register
//   err               - sticky protocol error
module operand_scoreboard #(
   parameter int unsigned NREG = operand_pkg::NREG
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  rd1_en,
   input  operand_pkg::reg_sel_t rd1_sel,
   input  logic                  rd2_en,
   input  operand_pkg::reg_sel_t rd2_sel,
   input  logic                  wr_en,
   input  operand_pkg::reg_sel_t wr_sel,
   input  logic                  iss_en,
   input  operand_pkg::reg_sel_t iss_sel,
   output logic                  stall,
   output logic [NREG-1:0]       pend,
   output logic                  err
);
   import operand_pkg::*;

   logic            hit1;
   logic            hit2;
   logic            iss_go;
   logic            err_set;
   logic [NREG-1:0] pend_nxt;

`ifdef OPERAND_REGFILE_BYPASS_EN
   assign hit1 = wr_en & (wr_sel == rd1_sel);
   assign hit2 = wr_en & (wr_sel == rd2_sel);
`else
   assign hit1 = 1'b0;
   assign hit2 = 1'b0;
`endif

   assign stall  = (rd1_en & pend[rd1_sel] & ~hit1) |
                   (rd2_en & pend[rd2_sel] & ~hit2);

   // An issue while decode is held is not a real issue.
   assign iss_go = iss_en & ~stall;

   // Clear first, then set: a same-edge issue keeps the bit for the newer producer.
   always_comb begin
      pend_nxt = pend;
      if (wr_en)  pend_nxt[wr_sel]  = 1'b0;
      if (iss_go) pend_nxt[iss_sel] = 1'b1;
   end

   assign err_set = (iss_go & pend[iss_sel] & ~(wr_en & (wr_sel == iss_sel))) |
                    (wr_en & ~pend[wr_sel]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend <= '0;
         err  <= 1'b0;
      end else begin
         pend <= pend_nxt;
         if (err_set) err <= 1'b1;
      end
   end
endmodule

// File: rtl/operand_regfile.sv
// Architectural register file feeding the execute-stage ALU operands, with a
// write-back scoreboard that stalls decode on reads of in-flight registers.
// Optional feature macro: OPERAND_REGFILE_BYPASS_EN (same-cycle write data is
// forwarded onto the read ports and clears the matching stall).
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   rd1_en/sel/data     - port-1 read (ALU A); enable only affects stall
//   rd2_en/sel/data     - port-2 read (ALU B); enable only affects stall
//   wr_en/sel/data      - write-back port
//   iss_en/iss_sel      - destination of the issuing instruction
//   stall, pend, err    - scoreboard status
module operand_regfile #(
   parameter int unsigned NREG = operand_pkg::NREG,
   parameter int unsigned DW   = operand_pkg::DW
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  rd1_en,
   input  operand_pkg::reg_sel_t rd1_sel,
   output logic [DW-1:0]         rd1_data,
   input  logic                  rd2_en,
   input  operand_pkg::reg_sel_t rd2_sel,
   output logic [DW-1:0]         rd2_data,
   input  logic                  wr_en,
   input  operand_pkg::reg_sel_t wr_sel,
   input  logic [DW-1:0]         wr_data,
   input  logic                  iss_en,
   input  operand_pkg::reg_sel_t iss_sel,
   output logic                  stall,
   output logic [NREG-1:0]       pend,
   output logic                  err
);
   import operand_pkg::*;

   logic [DW-1:0] regs [NREG];

   // Explicit per-register reset keeps this out of RAM inference.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < NREG; i++) regs[i] <= '0;
      end else if (wr_en) begin
         regs[wr_sel] <= wr_data;
      end
   end

`ifdef OPERAND_REGFILE_BYPASS_EN
   assign rd1_data = (wr_en && (wr_sel == rd1_sel)) ? wr_data : regs[rd1_sel];
   assign rd2_data = (wr_en && (wr_sel == rd2_sel)) ? wr_data : regs[rd2_sel];
`else
   assign rd1_data = regs[rd1_sel];
   assign rd2_data = regs[rd2_sel];
`endif

   operand_scoreboard #(.NREG(NREG)) u_sb (
      .clk     (clk),
      .rst_n   (rst_n),
      .rd1_en  (rd1_en),
      .rd1_sel (rd1_sel),
      .rd2_en  (rd2_en),
      .rd2_sel (rd2_sel),
      .wr_en   (wr_en),
      .wr_sel  (wr_sel),
      .iss_en  (iss_en),
      .iss_sel (iss_sel),
      .stall   (stall),
      .pend    (pend),
      .err     (err)
   );
endmodule

// File: tb/tb_operand_regfile.sv
module tb_operand_regfile;
`ifdef OPERAND_REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        rd1_en, rd2_en, wr_en, iss_en;
   logic [2:0]  rd1_sel, rd2_sel, wr_sel, iss_sel;
   logic [15:0] rd1_data, rd2_data, wr_data;
   logic        stall, err;
   logic [7:0]  pend;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   operand_regfile #(.NREG(8), .DW(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .rd1_en(rd1_en), .rd1_sel(rd1_sel), .rd1_data(rd1_data),
      .rd2_en(rd2_en), .rd2_sel(rd2_sel), .rd2_data(rd2_data),
      .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
      .iss_en(iss_en), .iss_sel(iss_sel),
      .stall(stall), .pend(pend), .err(err)
   );

   typedef struct {
      logic r1e; logic [2:0] r1s; logic r2e; logic [2:0] r2s;
      logic we;  logic [2:0] ws;  logic [15:0] wd;
      logic ie;  logic [2:0] isel;
      logic [15:0] e_r1; logic [15:0] e_r2; logic e_st;
      logic [7:0]  e_pend; logic e_err;
   } vec_t;

   vec_t vecs [12];

   // behavioural model state
   logic [15:0] mreg [8];
   logic [7:0]  mpend;
   logic        merr;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   task automatic idle();
      rd1_en = 0; rd1_sel = 0; rd2_en = 0; rd2_sel = 0;
      wr_en = 0; wr_sel = 0; wr_data = 0; iss_en = 0; iss_sel = 0;
   endtask

   task automatic do_reset();
      idle();
      rst_n = 1'b0;
      #3;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < 8; i++) mreg[i] = '0;
      mpend = '0;
      merr  = 1'b0;
   endtask

   function automatic vec_t mk(input logic r1e, input logic [2:0] r1s,
                               input logic r2e, input logic [2:0] r2s,
                               input logic we, input logic [2:0] ws, input logic [15:0] wd,
                               input logic ie, input logic [2:0] isel,
                               input logic [15:0] e_r1, input logic [15:0] e_r2,
                               input logic e_st, input logic [7:0] e_pend, input logic e_err);
      vec_t v;
      v.r1e = r1e; v.r1s = r1s; v.r2e = r2e; v.r2s = r2s;
      v.we = we; v.ws = ws; v.wd = wd; v.ie = ie; v.isel = isel;
      v.e_r1 = e_r1; v.e_r2 = e_r2; v.e_st = e_st; v.e_pend = e_pend; v.e_err = e_err;
      return v;
   endfunction

   initial begin
      idle();
      rst_n = 1'b0;
      #12;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // reset state on every register, both ports
      for (int i = 0; i < 8; i++) begin
         rd1_en = 1; rd2_en = 1; rd1_sel = 3'(i); rd2_sel = 3'(7 - i);
         #1;
         chk("reset_rd1", rd1_data, 0);
         chk("reset_rd2", rd2_data, 0);
         chk("reset_stall", stall, 0);
         chk("reset_pend", pend, 0);
         chk("reset_err", err, 0);
      end
      idle();
      @(posedge clk);
      #1;

      // directed table: comb outputs checked before the edge, pend/err after
      vecs[0]  = mk(0,0, 0,0, 0,0,16'h0000, 1,3, 16'h0000, 16'h0000, 0, 8'h08, 0);
      vecs[1]  = mk(0,3, 0,0, 1,3,16'hA5A5, 0,0, BYP ? 16'hA5A5 : 16'h0000, 16'h0000, 0, 8'h00, 0);
      vecs[2]  = mk(1,3, 1,3, 0,0,16'h0000, 0,0, 16'hA5A5, 16'hA5A5, 0, 8'h00, 0);
      vecs[3]  = mk(0,0, 0,0, 0,0,16'h0000, 1,5, 16'h0000, 16'h0000, 0, 8'h20, 0);
      vecs[4]  = mk(0,0, 1,5, 0,0,16'h0000, 0,0, 16'h0000, 16'h0000, 1, 8'h20, 0);
      vecs[5]  = mk(0,0, 1,5, 1,5,16'h1234, 0,0, 16'h0000, BYP ? 16'h1234 : 16'h0000, !BYP, 8'h00, 0);
      vecs[6]  = mk(0,0, 1,5, 0,0,16'h0000, 0,0, 16'h0000, 16'h1234, 0, 8'h00, 0);
      vecs[7]  = mk(0,0, 0,0, 0,0,16'h0000, 1,2, 16'h0000, 16'h0000, 0, 8'h04, 0);
      vecs[8]  = mk(0,0, 0,0, 1,2,16'h00FF, 1,2, 16'h0000, 16'h0000, 0, 8'h04, 0);
      vecs[9]  = mk(0,2, 0,2, 0,0,16'h0000, 1,6, 16'h00FF, 16'h00FF, 0, 8'h44, 0);
      vecs[10] = mk(0,0, 0,0, 0,0,16'h0000, 1,6, 16'h0000, 16'h0000, 0, 8'h44, 1);
      vecs[11] = mk(1,2, 0,0, 0,0,16'h0000, 0,0, 16'h00FF, 16'h0000, 1, 8'h44, 1);

      foreach (vecs[k]) begin
         rd1_en = vecs[k].r1e; rd1_sel = vecs[k].r1s;
         rd2_en = vecs[k].r2e; rd2_sel = vecs[k].r2s;
         wr_en = vecs[k].we; wr_sel = vecs[k].ws; wr_data = vecs[k].wd;
         iss_en = vecs[k].ie; iss_sel = vecs[k].isel;
         #1;
         chk($sformatf("vec%0d_rd1", k), rd1_data, vecs[k].e_r1);
         chk($sformatf("vec%0d_rd2", k), rd2_data, vecs[k].e_r2);
         chk($sformatf("vec%0d_stall", k), stall, vecs[k].e_st);
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d_pend", k), pend, vecs[k].e_pend);
         chk($sformatf("vec%0d_err", k), err, vecs[k].e_err);
      end

      // unexpected write-back after a fresh reset
      do_reset();
      wr_en = 1; wr_sel = 1; wr_data = 16'h7777;
      @(posedge clk);
      #1;
      idle();
      chk("unexp_wr_err", err, 1);
      chk("unexp_wr_pend", pend, 0);

      // R4=0xBEEF still pending, then asynchronous reset mid-cycle
      iss_en = 1; iss_sel = 4;
      @(posedge clk);
      #1;
      wr_en = 1; wr_sel = 4; wr_data = 16'hBEEF; iss_en = 1; iss_sel = 4;
      @(posedge clk);
      #1;
      idle();
      rd1_sel = 4;
      #1;
      chk("pre_arst_rd", rd1_data, 16'hBEEF);
      chk("pre_arst_pend", pend, 8'h10);
      rst_n = 1'b0;
      #1;
      chk("arst_rd", rd1_data, 0);
      chk("arst_pend", pend, 0);
      chk("arst_err", err, 0);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < 8; i++) mreg[i] = '0;
      mpend = '0;
      merr  = 1'b0;

      // randomized traffic against the behavioural model
      for (int n = 0; n < 400; n++) begin
         logic        h1, h2, est, go;
         logic [15:0] e1, e2;
         rd1_en = 1'($urandom); rd1_sel = 3'($urandom);
         rd2_en = 1'($urandom); rd2_sel = 3'($urandom);
         iss_en = ($urandom_range(0, 99) < 40); iss_sel = 3'($urandom);
         wr_data = 16'($urandom);
         wr_en = 0; wr_sel = 3'($urandom);
         if (mpend != 0 && $urandom_range(0, 99) < 60) begin
            wr_en = 1;
            for (int t = 0; t < 16 && !mpend[wr_sel]; t++) wr_sel = 3'($urandom);
         end else if ($urandom_range(0, 99) < 5) begin
            wr_en = 1;
         end
         h1 = BYP && wr_en && (wr_sel == rd1_sel);
         h2 = BYP && wr_en && (wr_sel == rd2_sel);
         e1 = h1 ? wr_data : mreg[rd1_sel];
         e2 = h2 ? wr_data : mreg[rd2_sel];
         est = (rd1_en && mpend[rd1_sel] && !h1) || (rd2_en && mpend[rd2_sel] && !h2);
         #1;
         chk("rand_rd1", rd1_data, e1);
         chk("rand_rd2", rd2_data, e2);
         chk("rand_stall", stall, est);
         @(posedge clk);
         go = iss_en && !est;
         if (wr_en && !mpend[wr_sel]) merr = 1;
         if (go && mpend[iss_sel] && !(wr_en && wr_sel == iss_sel)) merr = 1;
         if (wr_en) begin
            mreg[wr_sel]  = wr_data;
            mpend[wr_sel] = 0;
         end
         if (go) mpend[iss_sel] = 1;
         #1;
         chk("rand_pend", pend, mpend);
         chk("rand_err", err, merr);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
